// File: rtl/ps2_led_ctrl_pkg.sv
// rtl/ps2_led_ctrl_pkg.sv - state encoding and PS/2 keyboard command constants
package ps2_led_ctrl_pkg;

    typedef enum logic [2:0] {
        IDLE,
        INHIBIT,
        START,
        TXBITS,
        ACKBIT,
        WAITRESP,
        ERROR
    } state_t;

    localparam logic [7:0] CMD_SETLED = 8'hED;
    localparam logic [7:0] RSP_ACK    = 8'hFA;
    localparam logic [7:0] RSP_RESEND = 8'hFE;

    // Falling edges the host drives: d0..d7, parity, stop.
    localparam logic [3:0] TX_BITS = 4'd10;

    // Keyboard LED byte: scroll lock on bit0 carries kana, caps lock on bit2.
    function automatic logic [7:0] led_byte(input logic caps, input logic kana);
        return {5'b0, caps, 1'b0, kana};
    endfunction

endpackage

// File: rtl/ps2_tx_shift.sv
// rtl/ps2_tx_shift.sv - host-to-device PS/2 frame shifter with odd parity and clock fall detect
module ps2_tx_shift
    import ps2_led_ctrl_pkg::*;
(
    input  logic       CLK,
    input  logic       RSTb,
    input  logic       pclkS,
    input  logic       load,
    input  logic       shiftEn,
    input  logic [7:0] txByte,
    output logic       pclkFall,
    output logic [3:0] bitCnt,
    output logic       dataLow
);

    logic       pclkPrev;
    logic [9:0] frame;

    assign pclkFall = pclkPrev & ~pclkS;

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            pclkPrev <= 1'b0;
            frame    <= '0;
            bitCnt   <= '0;
            dataLow  <= 1'b0;
        end else begin
            pclkPrev <= pclkS;
            if (load) begin
                // Load also asserts the start bit; it holds until the first fall.
                frame   <= {1'b1, ~^txByte, txByte};
                bitCnt  <= '0;
                dataLow <= 1'b1;
            end else if (shiftEn && pclkFall && bitCnt != TX_BITS) begin
                dataLow <= ~frame[0];
                frame   <= {1'b0, frame[9:1]};
                bitCnt  <= bitCnt + 4'd1;
            end
        end
    end

endmodule

// File: rtl/ps2_led_ctrl.sv
// rtl/ps2_led_ctrl.sv - mirrors MSX caps/kana LEDs onto a PS/2 keyboard via the 0xED command
module ps2_led_ctrl
    import ps2_led_ctrl_pkg::*;
#(
    parameter int INHIBIT_CYC = 256,
    parameter int TIMEOUT_CYC = 32768,
    parameter int MAX_RETRY   = 3
) (
    input  logic       CLK,
    input  logic       RSTb,
    input  logic       pclkS,
    input  logic       dataS,
    input  logic       capsLed,
    input  logic       kanaLed,
    input  logic [7:0] rxCode,
    input  logic       rxRdy,
    output logic       clrRdy,
    output logic       rxOwn,
    output logic       rxHold,
    output logic       pclkOE,
    output logic       dataOE,
    output logic       busy,
    output logic       err
);

    localparam int TMR_CYC = (TIMEOUT_CYC > INHIBIT_CYC) ? TIMEOUT_CYC : INHIBIT_CYC;
    localparam int TMR_W   = $clog2(TMR_CYC + 1);
    localparam int RTY_W   = $clog2(MAX_RETRY + 2);

    state_t           state, nextState;
    logic [1:0]       sentLed, reqLed;
    logic             byteSel;
    logic [RTY_W-1:0] retryCnt;
    logic [TMR_W-1:0] tmr;
    logic             pclkFall, dataLow, loadTx, shiftEn;
    logic [3:0]       bitCnt;
    logic             fail, ackNext, ackLast, restartTmr;
    logic             ledPend, inhDone, tmrExpired, retryDone;
    logic [7:0]       txByte;

    assign ledPend    = {capsLed, kanaLed} != sentLed;
    assign inhDone    = tmr == TMR_W'(INHIBIT_CYC - 1);
    assign tmrExpired = tmr == TMR_W'(TIMEOUT_CYC - 1);
    assign retryDone  = retryCnt == RTY_W'(MAX_RETRY);
    assign txByte     = byteSel ? led_byte(reqLed[1], reqLed[0]) : CMD_SETLED;
    assign busy       = state != IDLE;

    ps2_tx_shift u_tx (
        .CLK      (CLK),
        .RSTb     (RSTb),
        .pclkS    (pclkS),
        .load     (loadTx),
        .shiftEn  (shiftEn),
        .txByte   (txByte),
        .pclkFall (pclkFall),
        .bitCnt   (bitCnt),
        .dataLow  (dataLow)
    );

    always_comb begin
        nextState = state;
        loadTx    = 1'b0;
        shiftEn   = 1'b0;
        fail      = 1'b0;
        ackNext   = 1'b0;
        ackLast   = 1'b0;
        clrRdy    = 1'b0;
        rxOwn     = 1'b0;
        rxHold    = 1'b0;
        pclkOE    = 1'b0;
        dataOE    = 1'b0;
        case (state)
            IDLE: begin
                rxOwn = 1'b1;
                if (ledPend) nextState = INHIBIT;
            end
            INHIBIT: begin
                pclkOE = 1'b1;
                rxHold = 1'b1;
                // A stale byte left over from before the frame is dropped once.
                clrRdy = rxRdy && (tmr == '0);
                if (inhDone) nextState = START;
            end
            START: begin
                rxHold    = 1'b1;
                dataOE    = 1'b1;
                loadTx    = 1'b1;
                nextState = TXBITS;
            end
            TXBITS: begin
                rxHold  = 1'b1;
                dataOE  = dataLow;
                shiftEn = 1'b1;
                if (tmrExpired) fail = 1'b1;
                else if (pclkFall && bitCnt == TX_BITS - 4'd1) nextState = ACKBIT;
            end
            ACKBIT: begin
                rxHold = 1'b1;
                if (tmrExpired) fail = 1'b1;
                else if (pclkFall) begin
                    if (!dataS) nextState = WAITRESP;
                    else fail = 1'b1;
                end
            end
            WAITRESP: begin
                if (rxRdy) begin
                    clrRdy = 1'b1;
                    if (rxCode == RSP_ACK) begin
                        if (byteSel) begin
                            ackLast   = 1'b1;
                            nextState = IDLE;
                        end else begin
                            ackNext   = 1'b1;
                            nextState = INHIBIT;
                        end
                    end else if (rxCode == RSP_RESEND) begin
                        fail = 1'b1;
                    end
                end else if (tmrExpired) begin
                    fail = 1'b1;
                end
            end
            ERROR: nextState = IDLE;
            default: nextState = IDLE;
        endcase
        if (fail) nextState = retryDone ? ERROR : INHIBIT;
        restartTmr = (nextState != state) && (nextState inside {INHIBIT, START, WAITRESP});
    end

    always_ff @(posedge CLK or negedge RSTb) begin
        if (!RSTb) begin
            state    <= IDLE;
            sentLed  <= 2'b00;
            reqLed   <= 2'b00;
            byteSel  <= 1'b0;
            retryCnt <= '0;
            tmr      <= '0;
            err      <= 1'b0;
        end else begin
            state <= nextState;
            if (restartTmr) tmr <= '0;
            else if (tmr != {TMR_W{1'b1}}) tmr <= tmr + 1'b1;
            if (state == IDLE && ledPend) begin
                reqLed   <= {capsLed, kanaLed};
                byteSel  <= 1'b0;
                retryCnt <= '0;
            end
            if (state == ERROR) begin
                err     <= 1'b1;
                sentLed <= {capsLed, kanaLed};
            end
            if (ackNext) begin
                byteSel  <= 1'b1;
                retryCnt <= '0;
            end
            // Commit what was actually sent, so a change mid-transfer re-requests.
            if (ackLast) sentLed <= reqLed;
            if (fail && !retryDone) retryCnt <= retryCnt + 1'b1;
        end
    end

endmodule

// File: tb/tb_ps2_led_ctrl.sv
// tb/tb_ps2_led_ctrl.sv - scoreboard bench with a PS/2 keyboard model for ps2_led_ctrl
module tb_ps2_led_ctrl;

    localparam int INH_CYC = 256;
    localparam int TMO_CYC = 2048;
    localparam int RETRIES = 3;

    logic       CLK = 1'b0;
    logic       RSTb = 1'b0;
    logic       capsLed = 1'b0;
    logic       kanaLed = 1'b0;
    logic [7:0] rxCode = 8'h00;
    logic       rxRdy = 1'b0;
    logic       rxPush = 1'b0;
    logic [7:0] rxPushCode = 8'h00;
    logic       kbdClkLow = 1'b0;
    logic       kbdDataLow = 1'b0;
    logic       pclkS, dataS;
    logic       clrRdy, rxOwn, rxHold, pclkOE, dataOE, busy, err;

    int         nTests = 0;
    int         nFail = 0;
    int         clrCnt = 0;
    int         oeRun = 0, inhLen = 0, inhCnt = 0, cyc = 0, lastRise = 0, riseGap = 0;
    logic [7:0] expQ[$];

    assign pclkS = ~pclkOE & ~kbdClkLow;
    assign dataS = ~dataOE & ~kbdDataLow;

    ps2_led_ctrl #(
        .INHIBIT_CYC (INH_CYC),
        .TIMEOUT_CYC (TMO_CYC),
        .MAX_RETRY   (RETRIES)
    ) dut (
        .CLK     (CLK),
        .RSTb    (RSTb),
        .pclkS   (pclkS),
        .dataS   (dataS),
        .capsLed (capsLed),
        .kanaLed (kanaLed),
        .rxCode  (rxCode),
        .rxRdy   (rxRdy),
        .clrRdy  (clrRdy),
        .rxOwn   (rxOwn),
        .rxHold  (rxHold),
        .pclkOE  (pclkOE),
        .dataOE  (dataOE),
        .busy    (busy),
        .err     (err)
    );

    always #5 CLK = ~CLK;

    // Receiver stand-in: a byte stays ready until the DUT consumes it.
    always @(posedge CLK) begin
        if (clrRdy) begin
            rxRdy  <= 1'b0;
            clrCnt <= clrCnt + 1;
        end else if (rxPush) begin
            rxRdy  <= 1'b1;
            rxCode <= rxPushCode;
        end
    end

    // Clock-inhibit monitor: pulse count, length of last pulse, spacing of rises.
    always @(negedge CLK) begin
        cyc <= cyc + 1;
        if (pclkOE) begin
            oeRun <= oeRun + 1;
            if (oeRun == 0) begin
                inhCnt   <= inhCnt + 1;
                riseGap  <= cyc - lastRise;
                lastRise <= cyc;
            end
        end else begin
            if (oeRun != 0) inhLen <= oeRun;
            oeRun <= 0;
        end
    end

    initial begin
        #600000;
        $display("FAIL watchdog: simulation did not finish, got timeout, want completion");
        $fatal(1, "watchdog");
    end

    task automatic check_eq(input string tag, input logic [31:0] act, input logic [31:0] exp);
        nTests++;
        if (act !== exp) begin
            nFail++;
            $display("FAIL %s: got 0x%0h, want 0x%0h", tag, act, exp);
        end
    endtask

    task automatic sb_pop(input logic [7:0] b);
        if (expQ.size() == 0) check_eq("sb_underflow", expQ.size(), 1);
        else check_eq("frame_byte", b, expQ.pop_front());
    endtask

    task automatic kbd_frame(input bit doAck, input int abortAt, output logic [7:0] b, output bit done);
        int n;
        logic [10:0] bits;
        done = 1'b0;
        b    = 8'h00;
        bits = '0;
        n = 0;
        while (!pclkOE && n < 4 * TMO_CYC) begin @(negedge CLK); n++; end
        check_eq("inhibit_seen", pclkOE, 1);
        if (!pclkOE) return;
        n = 0;
        while (pclkOE && n < 4 * TMO_CYC) begin @(negedge CLK); n++; end
        check_eq("start_bit", dataOE, 1);
        #1;
        check_eq("inhibit_len", inhLen, INH_CYC);
        for (int i = 0; i < 11; i++) begin
            if (i == 10) kbdDataLow = doAck;
            repeat (2) @(negedge CLK);
            kbdClkLow = 1'b1;
            repeat (10) @(negedge CLK);
            if (i == abortAt) begin
                check_eq("d4_driven_low", dataOE, 1);
                #2 RSTb = 1'b0;
                #1;
                check_eq("rst_pclk_release", pclkOE, 0);
                check_eq("rst_data_release", dataOE, 0);
                check_eq("rst_busy", busy, 0);
                kbdClkLow = 1'b0;
                repeat (3) @(negedge CLK);
                RSTb = 1'b1;
                return;
            end
            kbdClkLow = 1'b0;
            repeat (10) @(negedge CLK);
            bits[i]    = dataS;
            kbdDataLow = 1'b0;
        end
        b = bits[7:0];
        check_eq("parity", bits[8], ~^bits[7:0]);
        check_eq("stop_bit", bits[9], 1);
        done = 1'b1;
    endtask

    task automatic kbd_resp(input logic [7:0] code);
        int n;
        check_eq("resp_rxown", rxOwn, 0);
        check_eq("resp_rxhold", rxHold, 0);
        rxPushCode = code;
        rxPush     = 1'b1;
        @(negedge CLK);
        rxPush = 1'b0;
        n = 0;
        while (!clrRdy && n < 100) begin @(negedge CLK); n++; end
        check_eq("resp_clrrdy", clrRdy, 1);
        @(negedge CLK);
        check_eq("resp_consumed", rxRdy, 0);
    endtask

    task automatic frame_rsp(input bit doAck, input logic [7:0] rsp);
        logic [7:0] b;
        bit done;
        kbd_frame(doAck, -1, b, done);
        if (done) sb_pop(b);
        if (done && doAck) kbd_resp(rsp);
    endtask

    initial begin
        logic [7:0] b;
        bit done;
        int n, c0;

        repeat (3) @(negedge CLK);
        check_eq("rst_busy0", busy, 0);
        check_eq("rst_err0", err, 0);
        check_eq("rst_pclkoe0", pclkOE, 0);
        check_eq("rst_dataoe0", dataOE, 0);
        check_eq("rst_rxhold0", rxHold, 0);
        check_eq("rst_rxown1", rxOwn, 1);
        check_eq("rst_clrrdy0", clrRdy, 0);
        RSTb = 1'b1;
        repeat (5) @(negedge CLK);
        check_eq("idle_no_request", busy, 0);

        // Caps on: 0xED then 0x04, both acknowledged.
        capsLed = 1'b1;
        expQ.push_back(8'hED); expQ.push_back(8'h04);
        frame_rsp(1, 8'hFA);
        frame_rsp(1, 8'hFA);
        check_eq("caps_done_busy", busy, 0);
        check_eq("caps_done_err", err, 0);
        repeat (50) @(negedge CLK);
        check_eq("caps_no_repeat", busy, 0);

        // Kana on: data byte answered 0xFE once, resent once.
        kanaLed = 1'b1;
        expQ.push_back(8'hED); expQ.push_back(8'h05); expQ.push_back(8'h05);
        frame_rsp(1, 8'hFA);
        frame_rsp(1, 8'hFE);
        frame_rsp(1, 8'hFA);
        check_eq("resend_busy", busy, 0);
        check_eq("resend_err", err, 0);

        // Kana off: unrelated 0xAA is consumed before the ack.
        kanaLed = 1'b0;
        expQ.push_back(8'hED); expQ.push_back(8'h04);
        kbd_frame(1, -1, b, done);
        if (done) sb_pop(b);
        kbd_resp(8'hAA);
        check_eq("aa_rxown", rxOwn, 0);
        check_eq("aa_busy", busy, 1);
        check_eq("aa_no_inhibit", pclkOE, 0);
        kbd_resp(8'hFA);
        frame_rsp(1, 8'hFA);
        check_eq("aa_done_busy", busy, 0);

        // Caps off: first 0xED gets no ack bit and is resent.
        capsLed = 1'b0;
        expQ.push_back(8'hED); expQ.push_back(8'hED); expQ.push_back(8'h00);
        frame_rsp(0, 8'h00);
        frame_rsp(1, 8'hFA);
        frame_rsp(1, 8'hFA);
        check_eq("noack_busy", busy, 0);
        check_eq("noack_err", err, 0);

        // Stale received byte is discarded on entry to INHIBIT.
        rxPushCode = 8'h55;
        rxPush     = 1'b1;
        @(negedge CLK);
        rxPush = 1'b0;
        @(negedge CLK);
        check_eq("idle_keeps_rx", rxRdy, 1);
        c0 = clrCnt;
        kanaLed = 1'b1;
        expQ.push_back(8'hED); expQ.push_back(8'h01);
        kbd_frame(1, -1, b, done);
        if (done) sb_pop(b);
        check_eq("stale_clr_once", clrCnt - c0, 1);
        check_eq("stale_cleared", rxRdy, 0);
        kbd_resp(8'hFA);
        frame_rsp(1, 8'hFA);
        check_eq("stale_done_busy", busy, 0);

        // Reset mid-frame, then the whole request is sent again from 0xED.
        capsLed = 1'b1;
        expQ.push_back(8'hED); expQ.push_back(8'h05);
        kbd_frame(1, 4, b, done);
        check_eq("abort_frame_done", done, 0);
        expQ.delete();
        expQ.push_back(8'hED); expQ.push_back(8'h05);
        frame_rsp(1, 8'hFA);
        frame_rsp(1, 8'hFA);
        check_eq("rst_redo_busy", busy, 0);
        check_eq("rst_redo_err", err, 0);

        // Silent keyboard: all attempts time out and the block gives up.
        c0 = inhCnt;
        capsLed = 1'b0;
        n = 0;
        while (!err && n < 6 * (TMO_CYC + INH_CYC)) begin @(negedge CLK); n++; end
        check_eq("timeout_err", err, 1);
        check_eq("timeout_attempts", inhCnt - c0, RETRIES + 1);
        check_eq("timeout_gap", (riseGap >= TMO_CYC) && (riseGap <= TMO_CYC + INH_CYC + 8), 1);
        repeat (2) @(negedge CLK);
        check_eq("timeout_idle", busy, 0);
        check_eq("timeout_pclk_rel", pclkOE, 0);
        check_eq("timeout_data_rel", dataOE, 0);
        repeat (TMO_CYC + INH_CYC) @(negedge CLK);
        check_eq("timeout_no_rerequest", inhCnt - c0, RETRIES + 1);
        check_eq("timeout_err_sticky", err, 1);
        check_eq("sb_drained", expQ.size(), 0);

        $display("[TB] %0d tests run, %0d failed", nTests, nFail);
        $finish;
    end

endmodule

// File: doc/ps2_led_ctrl.md
PS2_LED_CTRL -- requirements
Module: ps2_led_ctrl

Interface
REQ-001 SHALL have parameter INHIBIT_CYC, default 256: CLK cycles the PS/2 clock is held low before transmit (123 us at 2.08 MHz).
REQ-002 SHALL have parameter TIMEOUT_CYC, default 32768: CLK cycles allowed per transmit frame or per response (15.7 ms).
REQ-003 SHALL have parameter MAX_RETRY, default 3: resends allowed per byte.
REQ-004 CLK  in  1  system clock, 2.08 MHz from the internal oscillator.
REQ-005 RSTb  in  1  reset, asynchronous, active-low.
REQ-006 pclkS  in  1  PS/2 clock, already two-flop synchronized.
REQ-007 dataS  in  1  PS/2 data, already two-flop synchronized.
REQ-008 capsLed, kanaLed  in  1 each  MSX LED levels to mirror on the keyboard.
REQ-009 rxCode  in  8  received byte from the existing PS/2 receiver.
REQ-010 rxRdy  in  1  rxCode valid, held until cleared.
REQ-011 clrRdy  out  1  one-cycle pulse that consumes rxCode.
REQ-012 rxOwn  out  1  1 = received bytes belong to the key FSM; 0 = this block consumes them.
REQ-013 rxHold  out  1  1 = receiver held in reset.
REQ-014 pclkOE, dataOE  out  1 each  1 = drive the PS/2 line low (open drain).
REQ-015 busy  out  1  1 = not in IDLE.
REQ-016 err  out  1  sticky; set when retries are exhausted.

Function
REQ-017 SHALL keep sentLed[1:0]; a request is pending when {capsLed,kanaLed} != sentLed in IDLE.
REQ-018 SHALL send byte 0xED, await its response, then send {5'b0,capsLed,1'b0,kanaLed} (caps on bit2, kana on scroll bit0) latched at the IDLE exit.
REQ-019 SHALL use states IDLE, INHIBIT, START, TXBITS, ACKBIT, WAITRESP, ERROR.
REQ-020 INHIBIT: pclkOE=1 and rxHold=1 for INHIBIT_CYC cycles, then go to START.
REQ-021 START: dataOE=1 (start bit), pclkOE=0, go to TXBITS next cycle.
REQ-022 TXBITS: on each pclkS falling edge (previous 1, current 0), drive the next bit: d0..d7 LSB first, then odd parity, then stop; dataOE = ~bit; stop releases data.
REQ-023 After the 10th falling edge SHALL enter ACKBIT; on the 11th falling edge, dataS==0 passes and the FSM goes to WAITRESP with rxHold=0; dataS==1 counts as a failure.
REQ-024 WAITRESP: rxOwn=0; on rxRdy, pulse clrRdy the same cycle.
REQ-025 WAITRESP: code 0xFA advances to the next byte, or after byte 1 updates sentLed and goes to IDLE.
REQ-026 WAITRESP: code 0xFE counts as a failure.
REQ-027 WAITRESP: any other code is discarded, without a state change.
REQ-028 A failure or timeout SHALL resend the same byte via INHIBIT and increment retryCnt; at retryCnt==MAX_RETRY it SHALL go to ERROR.
REQ-029 The timeout counter SHALL restart on entry to START and to WAITRESP; expiry in TXBITS/ACKBIT/WAITRESP is a failure.
REQ-030 ERROR: set err, release both lines, load sentLed with the current LEDs (no re-request loop), go to IDLE next cycle.
REQ-031 retryCnt SHALL clear when each new byte starts.
REQ-032 The parity/bit counter SHALL be 4 bits; the timeout counter SHALL be wide enough for TIMEOUT_CYC; neither SHALL wrap.
REQ-033 IDLE: rxOwn=1, rxHold=0, pclkOE=dataOE=0.
REQ-034 An LED change during a transfer SHALL be served by a new transfer after return to IDLE.
REQ-035 If rxRdy is already set on entry to INHIBIT, clrRdy SHALL pulse once, discarding that byte.

Reset
REQ-036 RSTb low SHALL asynchronously force IDLE, sentLed=00, all counters 0, err=0, clrRdy=0, pclkOE=dataOE=0, rxHold=0, rxOwn=1, busy=0.
REQ-037 Reset asserted mid-frame SHALL release both PS/2 lines immediately.

Structure
REQ-038 A shared package SHALL hold the state encoding and constants CMD_SETLED=0xED, RSP_ACK=0xFA, RSP_RESEND=0xFE.
REQ-039 A single sub-module ps2_tx_shift SHALL hold the frame shifter, parity and falling-edge detect; the FSM, timers and retry logic SHALL stay in ps2_led_ctrl.

Verification
REQ-040 capsLed 0->1, keyboard model ACKs everything -> frames 0xED then 0x04, clock low >=256 cycles before each, busy falls, sentLed=10.
REQ-041 Model answers 0xFE once to 0x04 -> 0x04 resent exactly once, then completes, err=0.
REQ-042 Model never clocks -> 4 transmit attempts of 0xED, each ~32768 cycles apart -> err=1, lines released, IDLE.
REQ-043 Model drives no ack bit (data high on 11th clock) -> counted as a failure, byte resent.
REQ-044 Model sends 0xAA then 0xFA in WAITRESP -> 0xAA consumed by clrRdy, rxOwn stays 0, 0xFA advances.
REQ-045 RSTb pulsed low during TXBITS bit 4 -> pclkOE=dataOE=0 the same cycle; after release, the pending LED change is retransmitted from 0xED.
